// File: rtl/hc595_pixel_driver.sv
// 74HC595 chain driver: shifts pixel bytes MSB-first, latches whole frames and PWMs nOE.
// The serial data pin doubles as stepper DIR; step pulses are sequenced between frames.
module hc595_pixel_driver #(
    parameter int CLK_DIV   = 2,
    parameter int NBYTES    = 1,
    parameter int PWM_BITS  = 4,
    parameter int DIR_SETUP = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [7:0]          din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                step_req,
    input  logic                step_dir,
    output logic                step_ack,
    output logic                sr_clk,
    output logic                sr_lat,
    output logic                sr_noe,
    output logic                dat_dir,
    output logic                step_out,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        WAIT_BYTE,
        LATCH,
        STEP_SETUP,
        STEP_PULSE
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
    localparam logic [3:0]  BYTE_LAST  = 4'(NBYTES - 1);

    state_t                state;
    logic [7:0]            shreg;
    logic [2:0]            bit_cnt;
    logic [3:0]            byte_cnt;
    logic [15:0]           tick;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  armed;
    logic                  ready_q;

    // A pending step in IDLE wins over din, so ready is withdrawn in that same cycle
    // to keep the handshake honest (valid&ready always means the byte was taken).
    assign din_ready = ready_q & ~((state == IDLE) & step_req);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tick       <= '0;
            pwm_cnt    <= '0;
            armed      <= 1'b0;
            ready_q    <= 1'b0;
            sr_clk     <= 1'b0;
            sr_lat     <= 1'b0;
            sr_noe     <= 1'b1;
            dat_dir    <= 1'b0;
            step_out   <= 1'b0;
            step_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            sr_noe     <= ~(armed & (pwm_cnt < brightness));
            sr_lat     <= 1'b0;
            frame_done <= 1'b0;
            step_ack   <= 1'b0;

            case (state)
                IDLE: begin
                    if (step_req) begin
                        dat_dir <= step_dir;
                        ready_q <= 1'b0;
                        tick    <= '0;
                        state   <= STEP_SETUP;
                    end else if (din_valid && ready_q) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        dat_dir <= din[7];
                        ready_q <= 1'b0;
                        tick    <= '0;
                        state   <= SHIFT_LO;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                SHIFT_LO: begin
                    if (tick == DIV_LAST) begin
                        tick   <= '0;
                        sr_clk <= 1'b1;
                        state  <= SHIFT_HI;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                SHIFT_HI: begin
                    if (tick == DIV_LAST) begin
                        tick    <= '0;
                        sr_clk  <= 1'b0;
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == BYTE_LAST) begin
                                state <= LATCH;
                            end else begin
                                ready_q <= 1'b1;
                                state   <= WAIT_BYTE;
                            end
                        end else begin
                            dat_dir <= shreg[6];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                WAIT_BYTE: begin
                    if (din_valid) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        dat_dir <= din[7];
                        ready_q <= 1'b0;
                        tick    <= '0;
                        state   <= SHIFT_LO;
                    end
                end

                LATCH: begin
                    sr_lat     <= 1'b1;
                    frame_done <= 1'b1;
                    byte_cnt   <= '0;
                    armed      <= 1'b1;
                    ready_q    <= 1'b1;
                    state      <= IDLE;
                end

                STEP_SETUP: begin
                    if (tick == SETUP_LAST) begin
                        tick     <= '0;
                        step_out <= 1'b1;
                        state    <= STEP_PULSE;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                STEP_PULSE: begin
                    if (tick == 16'd1) begin
                        tick     <= '0;
                        step_out <= 1'b0;
                        step_ack <= 1'b1;
                        ready_q  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
